bp_btb_unit: RTL and testbench
==============================

Name: bp_btb_unit

Overview:
- Parametrised branch prediction unit for the IF stage.
- Replaces the single global 2-bit counter plus fixed 16-entry target table with a direct-mapped BTB of 2^IDX_W entries. Each entry holds its own saturating counter.
- Looks up the fetch PC and returns a registered taken/target prediction one cycle later.
- Trains from EX branch resolution and raises a registered mispredict/redirect to IF.

Parameters:
- ADDR_W, 32, PC width in bits.
- IDX_W, 4, index bits; BTB depth = 2^IDX_W.
- CNT_W, 2, saturating counter width; predict taken when counter MSB = 1.
- CNT_INIT, 1, counter value written on reset and on invalidate.

Ports:
- clk  in  1  clock, rising edge.
- BP_rst_n  in  1  asynchronous active-low reset.
- BP_inv  in  1  invalidate all entries (synchronous, one cycle).
- IF_BP_valid  in  1  lookup request this cycle.
- IF_BP_pc  in  ADDR_W  fetch PC to look up.
- BP_IF_pred_valid  out  1  prediction below is valid (registered).
- BP_IF_pred_taken  out  1  predicted taken.
- BP_IF_pred_target  out  ADDR_W  predicted target; equals looked-up PC+4 when not taken.
- BP_IF_pred_cnt  out  CNT_W  counter snapshot, carried down the pipe.
- EX_BP_valid  in  1  resolved branch this cycle.
- EX_BP_pc  in  ADDR_W  PC of the branch instruction itself (not PC+4).
- EX_BP_taken  in  1  actual outcome.
- EX_BP_target  in  ADDR_W  actual taken target.
- EX_BP_pred_taken  in  1  prediction that travelled with the branch.
- EX_BP_pred_target  in  ADDR_W  predicted target that travelled with the branch.
- BP_IF_mispredict  out  1  one-cycle redirect pulse (registered).
- BP_IF_redirect_pc  out  ADDR_W  correct next PC.

Behaviour:
- Address split:
  - idx = pc[IDX_W+1:2]
  - tag = pc[ADDR_W-1:IDX_W+2]
  - pc[1:0] ignored.
- Entry contents: valid, tag, target[ADDR_W-1:0], cnt[CNT_W-1:0].
- Reset (asynchronous, BP_rst_n low):
  - All valid = 0, all cnt = CNT_INIT, targets/tags = 0.
  - All outputs = 0, except BP_IF_pred_cnt = CNT_INIT.
- Lookup (latency 1):
  - Edge after IF_BP_valid = 1: BP_IF_pred_valid = 1.
  - hit = valid & tag match.
  - BP_IF_pred_taken = hit & cnt[CNT_W-1].
  - BP_IF_pred_target = taken ? entry target : IF_BP_pc + 4 (mod 2^ADDR_W).
  - BP_IF_pred_cnt = hit ? cnt : CNT_INIT.
  - IF_BP_valid = 0 gives BP_IF_pred_valid = 0 next cycle; other prediction outputs hold their last value.
- Update on EX_BP_valid = 1 (written on the clock edge):
  - Hit, taken: cnt saturating-increments (stays at 2^CNT_W-1); target overwritten.
  - Hit, not taken: cnt saturating-decrements (stays at 0).
  - Miss, taken: allocate (valid = 1, new tag, target, cnt = 2^(CNT_W-1), i.e. weakly taken). Overwrites any resident entry.
  - Miss, not taken: no table change.
- Mispredict, registered with latency 1:
  - mp = EX_BP_valid & ((EX_BP_taken != EX_BP_pred_taken) | (EX_BP_taken & EX_BP_pred_target != EX_BP_target)).
  - BP_IF_mispredict = mp for exactly one cycle.
  - BP_IF_redirect_pc = EX_BP_taken ? EX_BP_target : EX_BP_pc + 4.
  - When mp = 0, redirect_pc holds its last value.
- Simultaneous lookup and update to the same idx: lookup returns the pre-update contents (read-before-write). No bypass.
- BP_inv:
  - Clears all valid bits and sets all cnt = CNT_INIT at the next edge.
  - Takes priority over a same-cycle update, which is dropped. The mispredict output is still generated.
  - A same-cycle lookup returns pre-invalidate contents.
- Counter arithmetic is CNT_W bits with no wrap. Target arithmetic (+4) wraps modulo 2^ADDR_W.

Optional Feature:
- Macro: BP_GSHARE_EN.
- Defined:
  - Adds an IDX_W-bit global history register, reset to 0.
  - Every update shifts in EX_BP_taken at the LSB.
  - BP_inv does not clear the history.
  - Lookup and update index = pc[IDX_W+1:2] XOR ghr. Tag is unchanged.
  - Because EX-side prediction state is not checkpointed, the update index uses the current ghr.
- Undefined: no history register; index = pc[IDX_W+1:2] exactly as above.

Test Plan:
- Reset, then lookup pc=0x40 -> next cycle pred_valid=1, taken=0, target=0x44, cnt=1.
- Update pc=0x40, taken=1, target=0x100, pred_taken=0 -> mispredict pulse, redirect=0x100. A later lookup of 0x40 gives taken=1, target=0x100, cnt=2.
- Three further taken updates to 0x40 -> cnt saturates at 3. Four not-taken updates -> cnt 0, and lookup gives taken=0, target=0x44.
- Alias: with 0x40 allocated, lookup 0x440 (same idx, different tag) -> taken=0. Taken update of 0x440 with target 0x200 evicts the 0x40 entry, and lookup 0x40 then misses.
- Correct prediction (pred_taken=1, pred_target=0x100, actual taken to 0x100) -> no mispredict. Wrong target (actual 0x180) -> mispredict, redirect=0x180.
- BP_inv asserted with a same-cycle taken update -> all lookups miss afterwards and the update is not stored. BP_rst_n asserted mid-stream -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/bp_btb_unit.sv
// bp_btb_unit: direct-mapped branch target buffer with per-entry saturating
// counters for the IF stage.
// - A lookup issued in one cycle returns its registered prediction in the next.
// - The table trains from EX branch resolution.
// - A registered one-cycle mispredict/redirect pulse is sent back to IF.
// Optional feature: define BP_GSHARE_EN to XOR a global history register into
// the table index (gshare); the default build uses the plain PC index.
module bp_btb_unit #(
    parameter int ADDR_W   = 32,
    parameter int IDX_W    = 4,
    parameter int CNT_W    = 2,
    parameter int CNT_INIT = 1
) (
    input  logic              clk,
    input  logic              BP_rst_n,
    input  logic              BP_inv,
    input  logic              IF_BP_valid,
    input  logic [ADDR_W-1:0] IF_BP_pc,
    output logic              BP_IF_pred_valid,
    output logic              BP_IF_pred_taken,
    output logic [ADDR_W-1:0] BP_IF_pred_target,
    output logic [CNT_W-1:0]  BP_IF_pred_cnt,
    input  logic              EX_BP_valid,
    input  logic [ADDR_W-1:0] EX_BP_pc,
    input  logic              EX_BP_taken,
    input  logic [ADDR_W-1:0] EX_BP_target,
    input  logic              EX_BP_pred_taken,
    input  logic [ADDR_W-1:0] EX_BP_pred_target,
    output logic              BP_IF_mispredict,
    output logic [ADDR_W-1:0] BP_IF_redirect_pc
);

    localparam int DEPTH = 1 << IDX_W;
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(CNT_INIT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1) << (CNT_W - 1);

    // Flattened views of the per-entry state, driven from the generate block.
    logic              valid_arr  [DEPTH];
    logic [TAG_W-1:0]  tag_arr    [DEPTH];
    logic [ADDR_W-1:0] target_arr [DEPTH];
    logic [CNT_W-1:0]  cnt_arr    [DEPTH];

    logic [IDX_W-1:0]  lk_idx;
    logic [IDX_W-1:0]  up_idx;
    logic [TAG_W-1:0]  lk_tag;
    logic [TAG_W-1:0]  up_tag;

    // Word-aligned PCs: the byte-offset bits never take part in index or tag.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{IF_BP_pc[1:0], EX_BP_pc[1:0]};

    assign lk_tag = IF_BP_pc[ADDR_W-1:IDX_W+2];
    assign up_tag = EX_BP_pc[ADDR_W-1:IDX_W+2];

`ifdef BP_GSHARE_EN
    logic [IDX_W-1:0] ghr_reg;

    // Global history: every resolved branch shifts its outcome in at the LSB;
    // invalidation leaves the history alone.
    always_ff @(posedge clk or negedge BP_rst_n) begin
        if (!BP_rst_n) begin
            ghr_reg <= '0;
        end else if (EX_BP_valid) begin
            ghr_reg <= (ghr_reg << 1) | IDX_W'(EX_BP_taken);
        end
    end

    // Update side uses the live history because EX carries no checkpoint.
    assign lk_idx = IF_BP_pc[IDX_W+1:2] ^ ghr_reg;
    assign up_idx = EX_BP_pc[IDX_W+1:2] ^ ghr_reg;
`else
    assign lk_idx = IF_BP_pc[IDX_W+1:2];
    assign up_idx = EX_BP_pc[IDX_W+1:2];
`endif

    // Lookup reads the current table contents, so a same-cycle update or
    // invalidate is not visible (read-before-write, no bypass).
    logic             lk_hit;
    logic             lk_taken;
    logic [CNT_W-1:0] lk_cnt;

    assign lk_hit   = valid_arr[lk_idx] && (tag_arr[lk_idx] == lk_tag);
    assign lk_cnt   = cnt_arr[lk_idx];
    assign lk_taken = lk_hit && lk_cnt[CNT_W-1];

    // Update-side read of the indexed entry and its saturated neighbours.
    logic             up_hit;
    logic [CNT_W-1:0] up_cnt;
    logic [CNT_W-1:0] up_cnt_inc;
    logic [CNT_W-1:0] up_cnt_dec;

    assign up_hit     = valid_arr[up_idx] && (tag_arr[up_idx] == up_tag);
    assign up_cnt     = cnt_arr[up_idx];
    assign up_cnt_inc = (up_cnt == CNT_MAX) ? CNT_MAX : up_cnt + CNT_W'(1);
    assign up_cnt_dec = (up_cnt == '0) ? '0 : up_cnt - CNT_W'(1);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic              entry_valid_reg;
            logic [TAG_W-1:0]  entry_tag_reg;
            logic [ADDR_W-1:0] entry_target_reg;
            logic [CNT_W-1:0]  entry_cnt_reg;
            logic              entry_sel;

            assign entry_sel = EX_BP_valid && (up_idx == IDX_W'(gi));

            // One BTB entry: invalidate wins over training; a miss allocates
            // only on a taken branch, evicting whatever was resident.
            always_ff @(posedge clk or negedge BP_rst_n) begin
                if (!BP_rst_n) begin
                    entry_valid_reg  <= 1'b0;
                    entry_tag_reg    <= '0;
                    entry_target_reg <= '0;
                    entry_cnt_reg    <= CNT_RST;
                end else if (BP_inv) begin
                    entry_valid_reg <= 1'b0;
                    entry_cnt_reg   <= CNT_RST;
                end else if (entry_sel) begin
                    if (up_hit) begin
                        if (EX_BP_taken) begin
                            entry_cnt_reg    <= up_cnt_inc;
                            entry_target_reg <= EX_BP_target;
                        end else begin
                            entry_cnt_reg <= up_cnt_dec;
                        end
                    end else if (EX_BP_taken) begin
                        entry_valid_reg  <= 1'b1;
                        entry_tag_reg    <= up_tag;
                        entry_target_reg <= EX_BP_target;
                        entry_cnt_reg    <= CNT_WT;
                    end
                end
            end

            assign valid_arr[gi]  = entry_valid_reg;
            assign tag_arr[gi]    = entry_tag_reg;
            assign target_arr[gi] = entry_target_reg;
            assign cnt_arr[gi]    = entry_cnt_reg;
        end
    endgenerate

    // Registered prediction; the payload holds when no lookup is requested.
    always_ff @(posedge clk or negedge BP_rst_n) begin
        if (!BP_rst_n) begin
            BP_IF_pred_valid  <= 1'b0;
            BP_IF_pred_taken  <= 1'b0;
            BP_IF_pred_target <= '0;
            BP_IF_pred_cnt    <= CNT_RST;
        end else begin
            BP_IF_pred_valid <= IF_BP_valid;
            if (IF_BP_valid) begin
                BP_IF_pred_taken  <= lk_taken;
                BP_IF_pred_target <= lk_taken ? target_arr[lk_idx]
                                              : IF_BP_pc + ADDR_W'(4);
                BP_IF_pred_cnt    <= lk_hit ? lk_cnt : CNT_RST;
            end
        end
    end

    // Mispredict: wrong direction, or taken with a wrong target.
    logic mp;
    assign mp = EX_BP_valid &&
                ((EX_BP_taken != EX_BP_pred_taken) ||
                 (EX_BP_taken && (EX_BP_pred_target != EX_BP_target)));

    // Registered redirect pulse; the redirect PC holds between mispredicts.
    always_ff @(posedge clk or negedge BP_rst_n) begin
        if (!BP_rst_n) begin
            BP_IF_mispredict  <= 1'b0;
            BP_IF_redirect_pc <= '0;
        end else begin
            BP_IF_mispredict <= mp;
            if (mp) begin
                BP_IF_redirect_pc <= EX_BP_taken ? EX_BP_target
                                                 : EX_BP_pc + ADDR_W'(4);
            end
        end
    end

endmodule

// File: tb/tb_bp_btb_unit.sv
// tb_bp_btb_unit: directed-vector bench for bp_btb_unit with hand-computed
// expectations (default parameters: ADDR_W=32, IDX_W=4, CNT_W=2, CNT_INIT=1).
module tb_bp_btb_unit;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 2;

    logic              clk;
    logic              BP_rst_n;
    logic              BP_inv;
    logic              IF_BP_valid;
    logic [ADDR_W-1:0] IF_BP_pc;
    logic              BP_IF_pred_valid;
    logic              BP_IF_pred_taken;
    logic [ADDR_W-1:0] BP_IF_pred_target;
    logic [CNT_W-1:0]  BP_IF_pred_cnt;
    logic              EX_BP_valid;
    logic [ADDR_W-1:0] EX_BP_pc;
    logic              EX_BP_taken;
    logic [ADDR_W-1:0] EX_BP_target;
    logic              EX_BP_pred_taken;
    logic [ADDR_W-1:0] EX_BP_pred_target;
    logic              BP_IF_mispredict;
    logic [ADDR_W-1:0] BP_IF_redirect_pc;

    int n_checks = 0;
    int n_fail   = 0;

    bp_btb_unit #(
        .ADDR_W  (32),
        .IDX_W   (4),
        .CNT_W   (2),
        .CNT_INIT(1)
    ) dut (
        .clk              (clk),
        .BP_rst_n         (BP_rst_n),
        .BP_inv           (BP_inv),
        .IF_BP_valid      (IF_BP_valid),
        .IF_BP_pc         (IF_BP_pc),
        .BP_IF_pred_valid (BP_IF_pred_valid),
        .BP_IF_pred_taken (BP_IF_pred_taken),
        .BP_IF_pred_target(BP_IF_pred_target),
        .BP_IF_pred_cnt   (BP_IF_pred_cnt),
        .EX_BP_valid      (EX_BP_valid),
        .EX_BP_pc         (EX_BP_pc),
        .EX_BP_taken      (EX_BP_taken),
        .EX_BP_target     (EX_BP_target),
        .EX_BP_pred_taken (EX_BP_pred_taken),
        .EX_BP_pred_target(EX_BP_pred_target),
        .BP_IF_mispredict (BP_IF_mispredict),
        .BP_IF_redirect_pc(BP_IF_redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pred(input string tag, input logic taken,
                              input logic [31:0] target, input logic [31:0] cnt);
        check_val({tag, ".valid"},  32'(BP_IF_pred_valid), 32'd1);
        check_val({tag, ".taken"},  32'(BP_IF_pred_taken), 32'(taken));
        check_val({tag, ".target"}, BP_IF_pred_target, target);
        check_val({tag, ".cnt"},    32'(BP_IF_pred_cnt), cnt);
    endtask

    task automatic do_lookup(input logic [31:0] pc);
        IF_BP_valid = 1'b1;
        IF_BP_pc    = pc;
        tick();
        IF_BP_valid = 1'b0;
    endtask

    task automatic do_update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                             input logic ptaken, input logic [31:0] ptgt);
        EX_BP_valid       = 1'b1;
        EX_BP_pc          = pc;
        EX_BP_taken       = taken;
        EX_BP_target      = tgt;
        EX_BP_pred_taken  = ptaken;
        EX_BP_pred_target = ptgt;
        tick();
        EX_BP_valid = 1'b0;
    endtask

    task automatic check_mp(input string tag, input logic mp, input logic [31:0] redirect);
        check_val({tag, ".mp"},       32'(BP_IF_mispredict), 32'(mp));
        check_val({tag, ".redirect"}, BP_IF_redirect_pc, redirect);
    endtask

    initial begin
        BP_rst_n = 1'b0;
        BP_inv = 1'b0;
        IF_BP_valid = 1'b0;
        IF_BP_pc = '0;
        EX_BP_valid = 1'b0;
        EX_BP_pc = '0;
        EX_BP_taken = 1'b0;
        EX_BP_target = '0;
        EX_BP_pred_taken = 1'b0;
        EX_BP_pred_target = '0;

        // Reset state.
        tick();
        check_val("rst.pred_valid",  32'(BP_IF_pred_valid), 32'd0);
        check_val("rst.pred_taken",  32'(BP_IF_pred_taken), 32'd0);
        check_val("rst.pred_target", BP_IF_pred_target, 32'h0);
        check_val("rst.pred_cnt",    32'(BP_IF_pred_cnt), 32'd1);
        check_val("rst.mispredict",  32'(BP_IF_mispredict), 32'd0);
        check_val("rst.redirect",    BP_IF_redirect_pc, 32'h0);
        BP_rst_n = 1'b1;
        tick();

        // Cold lookup misses: target is PC+4, counter snapshot is CNT_INIT.
        do_lookup(32'h40);
        check_pred("cold40", 1'b0, 32'h44, 32'd1);

        // Taken update on a miss allocates weakly taken and mispredicts.
        do_update(32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
        check_mp("alloc40", 1'b1, 32'h100);
        tick();
        check_mp("pulse_end", 1'b0, 32'h100);
        check_val("idle.pred_valid", 32'(BP_IF_pred_valid), 32'd0);

        do_lookup(32'h40);
        check_pred("hit40", 1'b1, 32'h100, 32'd2);
        tick();
        check_val("hold.pred_valid", 32'(BP_IF_pred_valid), 32'd0);
        check_val("hold.pred_target", BP_IF_pred_target, 32'h100);

        // Three correctly predicted taken updates: counter saturates at 3.
        for (int i = 0; i < 3; i++) begin
            do_update(32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
            check_val($sformatf("inc%0d.mp", i), 32'(BP_IF_mispredict), 32'd0);
        end
        do_lookup(32'h40);
        check_pred("sat_hi", 1'b1, 32'h100, 32'd3);

        // Four not-taken updates predicted taken: redirect to PC+4, counter to 0.
        for (int i = 0; i < 4; i++) begin
            do_update(32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
            check_mp($sformatf("dec%0d", i), 1'b1, 32'h44);
        end
        do_lookup(32'h40);
        check_pred("sat_lo", 1'b0, 32'h44, 32'd0);

        // Retrain 0x40 to taken (0 -> 1 -> 2).
        do_update(32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
        do_update(32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
        do_lookup(32'h40);
        check_pred("retrain40", 1'b1, 32'h100, 32'd2);

        // Alias 0x440: same index, different tag -> miss.
        do_lookup(32'h440);
        check_pred("alias_miss", 1'b0, 32'h444, 32'd1);
        do_update(32'h440, 1'b1, 32'h200, 1'b0, 32'h0);
        check_mp("alias_alloc", 1'b1, 32'h200);
        do_lookup(32'h440);
        check_pred("alias_hit", 1'b1, 32'h200, 32'd2);
        do_lookup(32'h40);
        check_pred("evicted40", 1'b0, 32'h44, 32'd1);

        // Correct prediction, then a wrong target.
        do_update(32'h440, 1'b1, 32'h200, 1'b1, 32'h200);
        check_val("correct.mp", 32'(BP_IF_mispredict), 32'd0);
        do_update(32'h440, 1'b1, 32'h180, 1'b1, 32'h200);
        check_mp("wrong_tgt", 1'b1, 32'h180);

        // PC+4 wraps at the top of the address space.
        do_update(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h0);
        check_mp("wrap_redirect", 1'b1, 32'h0);
        do_lookup(32'hFFFF_FFFC);
        check_pred("wrap_lookup", 1'b0, 32'h0, 32'd1);

        // Same-cycle lookup and update of one entry: lookup sees old contents.
        IF_BP_valid = 1'b1;
        IF_BP_pc = 32'h440;
        do_update(32'h440, 1'b1, 32'h300, 1'b1, 32'h180);
        IF_BP_valid = 1'b0;
        check_pred("rbw_old", 1'b1, 32'h180, 32'd3);
        do_lookup(32'h440);
        check_pred("rbw_new", 1'b1, 32'h300, 32'd3);

        // Invalidate with a same-cycle taken update and lookup.
        BP_inv = 1'b1;
        IF_BP_valid = 1'b1;
        IF_BP_pc = 32'h440;
        do_update(32'h84, 1'b1, 32'h500, 1'b0, 32'h0);
        BP_inv = 1'b0;
        IF_BP_valid = 1'b0;
        check_pred("inv_preread", 1'b1, 32'h300, 32'd3);
        check_mp("inv_mp", 1'b1, 32'h500);
        do_lookup(32'h84);
        check_pred("inv_drop84", 1'b0, 32'h88, 32'd1);
        do_lookup(32'h440);
        check_pred("inv_miss440", 1'b0, 32'h444, 32'd1);

        // Asynchronous reset mid-stream, away from any clock edge.
        IF_BP_valid = 1'b1;
        IF_BP_pc = 32'h40;
        do_update(32'h40, 1'b1, 32'h700, 1'b0, 32'h0);
        IF_BP_valid = 1'b0;
        check_mp("pre_rst", 1'b1, 32'h700);
        #1;
        BP_rst_n = 1'b0;
        #1;
        check_val("arst.pred_valid",  32'(BP_IF_pred_valid), 32'd0);
        check_val("arst.pred_target", BP_IF_pred_target, 32'h0);
        check_val("arst.pred_cnt",    32'(BP_IF_pred_cnt), 32'd1);
        check_val("arst.mispredict",  32'(BP_IF_mispredict), 32'd0);
        check_val("arst.redirect",    BP_IF_redirect_pc, 32'h0);
        BP_rst_n = 1'b1;
        tick();
        do_lookup(32'h40);
        check_pred("post_rst40", 1'b0, 32'h44, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
